// File: rtl/regfile_pkg.sv
// Shared types and sizes for the 8 x 16-bit register file
// and its hazard scoreboard.
package regfile_pkg;

  localparam int NUM_REGS = 8;
  localparam int ADDR_W   = 3;
  localparam int DATA_W   = 16;
  localparam int CNT_W    = 2;
  localparam int STAT_W   = 16;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;
  typedef logic [CNT_W-1:0]  sb_cnt_t;

  localparam reg_addr_t ZERO_REG = 3'd0;
  localparam sb_cnt_t   CNT_MAX  = '1;

endpackage

// File: rtl/regfile_scoreboard_ctrl_sb_counter.sv
// Per-register in-flight write counter (0..CNT_MAX),
// saturating in both directions.
module sb_counter
  import regfile_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    inc,
  input  logic    dec,
  output sb_cnt_t count,
  output logic    is_max
);

  assign is_max = (count == CNT_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      unique case (1'b1)
        (inc && !dec && !is_max):
          count <= count + 1'b1;
        (dec && !inc && count != '0):
          count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/regfile_scoreboard_ctrl.sv
// Hazard scoreboard and write-port sequencer for the
// register file; sole driver of the RF write port.
module regfile_scoreboard_ctrl
  import regfile_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_ra,
  input  logic [ADDR_W-1:0]   issue_rb,
  input  logic                issue_use_a,
  input  logic                issue_use_b,
  input  logic                issue_we,
  input  logic [ADDR_W-1:0]   issue_rw,
  output logic                stall,
  input  logic                wb_valid,
  input  logic [ADDR_W-1:0]   wb_rw,
  input  logic [DATA_W-1:0]   wb_data,
  output logic                rf_enableWrite,
  output logic [ADDR_W-1:0]   rf_RW,
  output logic [DATA_W-1:0]   rf_BusW,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [STAT_W-1:0]   stall_count,
  output logic                err_underflow
);

  sb_cnt_t             cnt [NUM_REGS];
  logic [NUM_REGS-1:0] max_v;
  logic                wb_nz;
  logic                wb_trk;
  logic                iss_trk;
  logic                hz_a;
  logic                hz_b;
  logic                hz_s;

  assign cnt[0]   = '0;
  assign max_v[0] = 1'b0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_cnt
    sb_counter u_cnt (
      .clk    (clk),
      .reset  (reset),
      .inc    (iss_trk && issue_rw == ADDR_W'(i)),
      .dec    (wb_trk && wb_rw == ADDR_W'(i)),
      .count  (cnt[i]),
      .is_max (max_v[i])
    );
  end

  assign wb_nz  = wb_valid && wb_rw != ZERO_REG;
  assign wb_trk = wb_nz && cnt[wb_rw] != '0;

  // A last outstanding write landing this cycle is
  // visible through the combinational RF write.
  always_comb begin
    hz_a = issue_use_a && issue_ra != ZERO_REG
        && cnt[issue_ra] != '0
        && !(cnt[issue_ra] == sb_cnt_t'(1)
             && wb_valid && wb_rw == issue_ra);
    hz_b = issue_use_b && issue_rb != ZERO_REG
        && cnt[issue_rb] != '0
        && !(cnt[issue_rb] == sb_cnt_t'(1)
             && wb_valid && wb_rw == issue_rb);
    hz_s = issue_we && issue_rw != ZERO_REG
        && max_v[issue_rw]
        && !(wb_trk && wb_rw == issue_rw);
  end

  assign stall = !reset && issue_valid
              && (hz_a || hz_b || hz_s);

  assign iss_trk = issue_valid && !stall
                && issue_we && issue_rw != ZERO_REG;

  assign rf_enableWrite = !reset && wb_nz;
  assign rf_RW   = reset ? '0 : wb_rw;
  assign rf_BusW = reset ? '0 : wb_data;

  always_comb begin
    busy_mask = '0;
    for (int i = 1; i < NUM_REGS; i++)
      busy_mask[i] = cnt[i] != '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count   <= '0;
      err_underflow <= 1'b0;
    end else begin
      if (stall && stall_count != '1)
        stall_count <= stall_count + 1'b1;
      if (wb_nz && cnt[wb_rw] == '0)
        err_underflow <= 1'b1;
    end
  end

endmodule

// File: doc/regfile_scoreboard_ctrl.md
Name: regfile_scoreboard_ctrl

Overview:
- Hazard scoreboard and write-port sequencer for the 8 x 16-bit register file (R0 hardwired zero, combinational write, always-on read).
- Sits between decode/issue and writeback.
- Tracks in-flight writes per register and asserts stall when an issuing instruction reads a register with a write still outstanding.
- Is the sole driver of the register file's write enable, write address and write data.

Parameters:
- NUM_REGS, 8, number of architectural registers.
- ADDR_W, 3, register address width (log2 NUM_REGS).
- DATA_W, 16, register data width.
- CNT_W, 2, width of each per-register in-flight counter (max 3 outstanding writes).
- STAT_W, 16, width of the stall-cycle statistics counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- issue_valid  in  1  decode presents an instruction this cycle.
- issue_ra  in  ADDR_W  source register A (feeds register file RA).
- issue_rb  in  ADDR_W  source register B (feeds register file RB).
- issue_use_a  in  1  instruction actually reads RA.
- issue_use_b  in  1  instruction actually reads RB.
- issue_we  in  1  instruction will write a destination.
- issue_rw  in  ADDR_W  destination register.
- stall  out  1  combinational; issue not accepted this cycle.
- wb_valid  in  1  writeback stage commits a result.
- wb_rw  in  ADDR_W  writeback destination.
- wb_data  in  DATA_W  writeback value.
- rf_enableWrite  out  1  register file write enable.
- rf_RW  out  ADDR_W  register file write address.
- rf_BusW  out  DATA_W  register file write data.
- busy_mask  out  NUM_REGS  bit i set when count[i] != 0; bit 0 always 0.
- stall_count  out  STAT_W  saturating count of stalled issue cycles.
- err_underflow  out  1  sticky; writeback arrived to a register with count 0.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, port name reset.
- Reset values: all counters 0, busy_mask 0, stall_count 0, err_underflow 0. stall, rf_enableWrite, rf_RW and rf_BusW are combinational and read 0 while reset is high.
- Reset mid-operation: all in-flight tracking is discarded immediately (asynchronous). The first cycle after deassertion behaves as an idle scoreboard.
- Accept: accept = issue_valid && !stall.
- Tracked issue: trk_iss = accept && issue_we && issue_rw != 0.
- Tracked writeback: trk_wb = wb_valid && wb_rw != 0 && count[wb_rw] != 0.
- Counter update at posedge, for each register r:
  - +1 when trk_iss targets r.
  - -1 when trk_wb targets r.
  - Both in the same cycle: count unchanged.
- Read hazard on source s (s != 0, its use bit set): count[s] != 0, except when count[s] == 1 && wb_valid && wb_rw == s. In that case there is no hazard, because the write lands in the same cycle through the combinational register file write.
- Structural hazard: issue_we && issue_rw != 0 && count[issue_rw] == 2^CNT_W-1, unless a tracked writeback to issue_rw occurs this cycle.
- stall = issue_valid && (hazard A || hazard B || structural hazard). Zero latency. stall is never asserted when issue_valid is 0.
- Register 0: never stalls, never counted, never written. With wb_rw == 0, rf_enableWrite is still driven 0.
- Writeback pass-through, zero latency:
  - rf_enableWrite = wb_valid && wb_rw != 0.
  - rf_RW = wb_rw.
  - rf_BusW = wb_data.
  - Underflow writes still pass through to the register file.
- Underflow: wb_valid && wb_rw != 0 && count[wb_rw] == 0 sets err_underflow at posedge. The counter stays 0. The flag clears only on reset.
- Writebacks are in order per register; the WAW ordering is therefore covered by the counter.
- stall_count: increments at posedge when stall is 1. Holds at 2^STAT_W-1.
- No internal FSM beyond the counters. Each counter behaves as a 4-state up/down machine (0..3) with the saturation rules above.

Decomposition:
- Shared package regfile_pkg:
  - constants NUM_REGS, ADDR_W, DATA_W, CNT_W, ZERO_REG = 3'd0.
  - typedef reg_addr_t = logic [ADDR_W-1:0].
  - typedef reg_data_t = logic [DATA_W-1:0].
  - typedef sb_cnt_t = logic [CNT_W-1:0].
- One sub-module, sb_counter: a single per-register up/down counter with inc, dec, count and is_max outputs, instantiated NUM_REGS-1 times (R1..R7).
- The hazard logic and statistics stay in the top module.

Test Plan:
- Reset, then issue rw=3 with we; next cycle issue ra=3 with use_a -> stall=1, busy_mask=8'h08. Then wb_valid rw=3 data=16'hBEEF -> stall drops in that same cycle, rf_enableWrite=1, rf_RW=3, rf_BusW=16'hBEEF. Following cycle busy_mask=0.
- Issue rw=0 with we, then read ra=0 -> stall never asserts, busy_mask stays 0. wb_rw=0 -> rf_enableWrite=0.
- Three back-to-back issues to rw=5, then a fourth issue to rw=5 with no wb -> stall=1 (structural). Repeat with wb_rw=5 in the same cycle -> accepted, count stays 3.
- Same cycle issue rw=2 with we and wb_rw=2 while count[2]=1 -> count remains 1, busy_mask[2]=1, no stall on a concurrent read of rb=2.
- wb_valid rw=6 with count[6]=0 -> err_underflow=1 next cycle, stays 1 through later traffic. rf_enableWrite=1 that cycle.
- Hold a hazard for 5 cycles -> stall_count=5. Assert reset mid-stall -> stall_count=0, busy_mask=0, stall=0 immediately. Preload stall_count to 16'hFFFF and stall -> it holds at 16'hFFFF.
